// File: rtl/tracer_contour_write_ctrl_if.sv
// Host-side and tracer-BRAM signals of the contour write controller, bundled.
// slave = the controller itself, master = host / buffer model side.
interface tracer_contour_write_ctrl_if;
    logic        write_start;
    logic [7:0]  trace_id;
    logic [7:0]  center_row;
    logic [8:0]  center_col;
    logic        contour_valid;
    logic        contour_ready;
    logic        contour_data;
    logic        busy;
    logic        write_end;
    logic        tracer_buf_en;
    logic [3:0]  tracer_buf_we;
    logic [31:0] tracer_buf_addr;
    logic [31:0] tracer_buf_din;

    modport slave (
        input  write_start, trace_id, center_row, center_col,
        input  contour_valid, contour_data,
        output contour_ready, busy, write_end,
        output tracer_buf_en, tracer_buf_we, tracer_buf_addr, tracer_buf_din
    );

    modport master (
        output write_start, trace_id, center_row, center_col,
        output contour_valid, contour_data,
        input  contour_ready, busy, write_end,
        input  tracer_buf_en, tracer_buf_we, tracer_buf_addr, tracer_buf_din
    );
endinterface

// File: rtl/tracer_contour_write_ctrl.sv
// Packs a trace center and a serial contour bitstream into tracer-buffer words.
// Define TRACER_WRITE_CHECKSUM_EN to append an XOR checksum word to every trace slot.
module tracer_contour_write_ctrl #(
    parameter int          CONTOUR_BITS = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_aresetn,
    tracer_contour_write_ctrl_if.slave         bus
);

    localparam int CW = CONTOUR_BITS / 32;
`ifdef TRACER_WRITE_CHECKSUM_EN
    localparam int WPT = CW + 2;
`else
    localparam int WPT = CW + 1;
`endif
    localparam int          WW         = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(CW - 1);
    localparam logic [31:0] SLOT_BYTES = 32'(WPT * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CENTER,
        ST_COLLECT,
        ST_LAST,
`ifdef TRACER_WRITE_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   slot_base_reg, slot_base_next;
    logic [31:0]   word_reg, word_next;
    logic [31:0]   word_filled;
    logic [4:0]    bit_cnt_reg, bit_cnt_next;
    logic [WW-1:0] word_cnt_reg, word_cnt_next;
    logic          en_reg, en_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   din_reg, din_next;
    logic          ready_reg, ready_next;
    logic          busy_reg, busy_next;
    logic          end_reg, end_next;
`ifdef TRACER_WRITE_CHECKSUM_EN
    logic [31:0]   cksum_reg, cksum_next;
`endif

    logic handshake;
    assign handshake = bus.contour_valid & ready_reg;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg     <= ST_IDLE;
            slot_base_reg <= '0;
            word_reg      <= '0;
            bit_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            en_reg        <= 1'b0;
            addr_reg      <= '0;
            din_reg       <= '0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            end_reg       <= 1'b0;
`ifdef TRACER_WRITE_CHECKSUM_EN
            cksum_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            slot_base_reg <= slot_base_next;
            word_reg      <= word_next;
            bit_cnt_reg   <= bit_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            en_reg        <= en_next;
            addr_reg      <= addr_next;
            din_reg       <= din_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            end_reg       <= end_next;
`ifdef TRACER_WRITE_CHECKSUM_EN
            cksum_reg     <= cksum_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        slot_base_next = slot_base_reg;
        word_next      = word_reg;
        bit_cnt_next   = bit_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        en_next        = 1'b0;
        addr_next      = addr_reg;
        din_next       = din_reg;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        end_next       = 1'b0;
`ifdef TRACER_WRITE_CHECKSUM_EN
        cksum_next     = cksum_reg;
`endif
        // Word as it stands once the bit offered this cycle is inserted.
        word_filled              = word_reg;
        word_filled[bit_cnt_reg] = bus.contour_data;

        case (state_reg)
            ST_IDLE: begin
                if (bus.write_start) begin
                    slot_base_next = BASE_ADDR + 32'(bus.trace_id) * SLOT_BYTES;
                    en_next        = 1'b1;
                    addr_next      = BASE_ADDR + 32'(bus.trace_id) * SLOT_BYTES;
                    din_next       = {7'b0, bus.center_col, 8'b0, bus.center_row};
                    busy_next      = 1'b1;
                    bit_cnt_next   = '0;
                    word_cnt_next  = '0;
`ifdef TRACER_WRITE_CHECKSUM_EN
                    cksum_next     = '0;
`endif
                    state_next     = ST_CENTER;
                end
            end
            ST_CENTER: begin
                ready_next = 1'b1;
                state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (handshake) begin
                    word_next    = word_filled;
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    if (bit_cnt_reg == 5'd31) begin
                        // Completed word goes out next cycle while collection continues.
                        en_next       = 1'b1;
                        addr_next     = slot_base_reg + 32'(word_cnt_reg) * 32'd4 + 32'd4;
                        din_next      = word_filled;
                        word_cnt_next = word_cnt_reg + WW'(1);
`ifdef TRACER_WRITE_CHECKSUM_EN
                        cksum_next    = cksum_reg ^ word_filled;
`endif
                        if (word_cnt_reg == LAST_WORD) begin
                            ready_next = 1'b0;
                            state_next = ST_LAST;
                        end
                    end
                end
            end
            ST_LAST: begin
`ifdef TRACER_WRITE_CHECKSUM_EN
                en_next    = 1'b1;
                addr_next  = slot_base_reg + 32'((CW + 1) * 4);
                din_next   = cksum_reg;
                state_next = ST_CKSUM;
`else
                busy_next  = 1'b0;
                end_next   = 1'b1;
                state_next = ST_DONE;
`endif
            end
`ifdef TRACER_WRITE_CHECKSUM_EN
            ST_CKSUM: begin
                busy_next  = 1'b0;
                end_next   = 1'b1;
                state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.contour_ready   = ready_reg;
    assign bus.busy            = busy_reg;
    assign bus.write_end       = end_reg;
    assign bus.tracer_buf_en   = en_reg;
    assign bus.tracer_buf_we   = {4{en_reg}};
    assign bus.tracer_buf_addr = addr_reg;
    assign bus.tracer_buf_din  = din_reg;

endmodule

// File: tb/tb_tracer_contour_write_ctrl.sv
// Randomised bench for tracer_contour_write_ctrl: observed BRAM writes and timing are
// compared with a slot-layout model built from the contour bits (TRACER_WRITE_CHECKSUM_EN aware).
module tb_tracer_contour_write_ctrl;

    localparam int NB = 1024;
    localparam int CW = NB / 32;
`ifdef TRACER_WRITE_CHECKSUM_EN
    localparam int WPT     = CW + 2;
    localparam int END_LAT = 3;
`else
    localparam int WPT     = CW + 1;
    localparam int END_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tracer_contour_write_ctrl_if bus ();

    tracer_contour_write_ctrl #(
        .CONTOUR_BITS(NB),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: every BRAM write plus handshake / done timing, sampled mid-cycle.
    int          cyc = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          start_cyc = 0;
    int          first_rdy_cyc = -1;
    int          last_hs_cyc = 0;
    int          end_cyc = 0;
    int          end_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tracer_buf_en) begin
            check("we_when_en", {28'b0, bus.tracer_buf_we}, 32'hF);
            wa_q.push_back(bus.tracer_buf_addr);
            wd_q.push_back(bus.tracer_buf_din);
            wc_q.push_back(cyc);
        end else if (bus.tracer_buf_we != 4'b0000) begin
            check("we_when_idle", {28'b0, bus.tracer_buf_we}, 32'h0);
        end
        if (bus.write_start && !bus.busy && rst_n) start_cyc = cyc;
        if (bus.contour_ready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
        if (bus.contour_valid && bus.contour_ready) last_hs_cyc = cyc;
        if (bus.write_end) begin
            end_cyc = cyc;
            end_count++;
            check("busy_at_end", {31'b0, bus.busy}, 32'h0);
        end
    end

    // Reference model: contour bits and the slot image they should produce.
    logic        bits [NB];
    logic [31:0] exp_addr [WPT];
    logic [31:0] exp_data [WPT];

    task automatic make_bits(input int mode);
        for (int k = 0; k < NB; k++) begin
            case (mode)
                0:       bits[k] = (k % 2) == 1;
                1:       bits[k] = 1'($urandom_range(0, 1));
                default: bits[k] = 1'b1;
            endcase
        end
    endtask

    task automatic build_expect(input int id, input int row, input int col);
        logic [31:0] base;
        base = 32'(id * WPT * 4);
        for (int i = 0; i < WPT; i++) begin
            exp_addr[i] = base + 32'(i * 4);
            exp_data[i] = 32'h0;
        end
        exp_data[0] = 32'(col * 65536 + row);
        for (int k = 0; k < NB; k++)
            exp_data[1 + k / 32][k % 32] = bits[k];
`ifdef TRACER_WRITE_CHECKSUM_EN
        for (int w = 1; w <= CW; w++)
            exp_data[CW + 1] = exp_data[CW + 1] ^ exp_data[w];
`endif
    endtask

    task automatic clear_monitor();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        first_rdy_cyc = -1;
        end_count = 0;
    endtask

    task automatic pulse_start(input int id, input int row, input int col);
        @(posedge clk); #1;
        bus.trace_id    = 8'(id);
        bus.center_row  = 8'(row);
        bus.center_col  = 9'(col);
        bus.write_start = 1'b1;
        @(posedge clk); #1;
        bus.write_start = 1'b0;
    endtask

    // gap_mode: 0 full rate, 1 valid every other cycle, 2 random valid.
    task automatic drive_bits(input int count, input int gap_mode, input bit inject, input int id);
        int   k;
        int   guard;
        logic v;
        logic rdy;
        k = 0;
        guard = 0;
        while (k < count && guard < 20000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.contour_valid = v;
            bus.contour_data  = bits[k];
            bus.write_start   = inject && (k == 100);
            bus.trace_id      = (inject && k == 100) ? 8'd7 : 8'(id);
            @(negedge clk);
            rdy = bus.contour_ready;
            @(posedge clk); #1;
            if (v && rdy) k++;
            guard++;
        end
        bus.contour_valid = 1'b0;
        bus.write_start   = 1'b0;
        bus.trace_id      = 8'(id);
        if (k < count) check("bits_accepted", 32'(k), 32'(count));
    endtask

    task automatic run_trace(input int id, input int row, input int col,
                             input int bit_mode, input int gap_mode, input bit inject);
        int g;
        make_bits(bit_mode);
        build_expect(id, row, col);
        clear_monitor();
        pulse_start(id, row, col);
        drive_bits(NB, gap_mode, inject, id);
        g = 0;
        while (end_count == 0 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("end_pulses", 32'(end_count), 32'd1);
        check("n_writes", 32'(wa_q.size()), 32'(WPT));
        for (int i = 0; i < WPT && i < wa_q.size(); i++) begin
            check($sformatf("addr[%0d]", i), wa_q[i], exp_addr[i]);
            check($sformatf("data[%0d]", i), wd_q[i], exp_data[i]);
        end
        if (wc_q.size() > CW) begin
            check("center_lat", 32'(wc_q[0]), 32'(start_cyc + 1));
            check("last_word_lat", 32'(wc_q[CW]), 32'(last_hs_cyc + 1));
        end
        check("ready_lat", 32'(first_rdy_cyc), 32'(start_cyc + 2));
        check("end_lat", 32'(end_cyc), 32'(last_hs_cyc + END_LAT));
        $display("trace id=%0d gap_mode=%0d writes=%0d start=%0d last_bit=%0d end=%0d",
                 id, gap_mode, wa_q.size(), start_cyc, last_hs_cyc, end_cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {24'b0, bus.tracer_buf_en, bus.tracer_buf_we, bus.contour_ready,
                              bus.busy, bus.write_end}, 32'h0);
        check({tag, "_addr"}, bus.tracer_buf_addr, 32'h0);
        check({tag, "_din"}, bus.tracer_buf_din, 32'h0);
    endtask

    initial begin
        int n8;
        bus.write_start   = 1'b0;
        bus.trace_id      = 8'd0;
        bus.center_row    = 8'd0;
        bus.center_col    = 9'd0;
        bus.contour_valid = 1'b0;
        bus.contour_data  = 1'b0;

        // Reset and idle behaviour.
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_monitor();
        bus.contour_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, bus.contour_ready}, 32'h0);
        end
        bus.contour_valid = 1'b0;
        check("idle_writes", 32'(wa_q.size()), 32'h0);
        $display("idle: writes=%0d", wa_q.size());

        // Center example, full-rate alternating pattern, backpressure with ignored start.
        run_trace(2, 8'h5A, 9'h1C3, 1, 0, 1'b0);
        run_trace(0, 8'h11, 9'h022, 0, 0, 1'b0);
        run_trace(0, 8'h11, 9'h022, 0, 1, 1'b1);

        // Reset after 40 accepted bits: word 1 was written, word 2 never is.
        make_bits(1);
        build_expect(0, 8'h33, 9'h144);
        clear_monitor();
        pulse_start(0, 8'h33, 9'h144);
        drive_bits(40, 0, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n8 = 0;
        foreach (wa_q[i]) if (wa_q[i] == 32'd8) n8++;
        check("midrst_no_addr8", 32'(n8), 32'h0);
        check("midrst_n_writes", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) check("midrst_word1", wd_q[1], exp_data[1]);
        $display("reset mid-op: writes=%0d", wa_q.size());

        // Normal runs afterwards: random gaps, high slot, all-ones checksum case.
        run_trace(5, $urandom_range(0, 255), $urandom_range(0, 511), 1, 2, 1'b0);
        run_trace(255, 8'hFF, 9'h1FF, 1, 0, 1'b0);
        run_trace(1, 8'h01, 9'h002, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
